// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressable word RAM with RV32I sub-word access
// plus a 16-byte MMIO status window (cycle/load/store counters, sticky misalignment error).
module dmem_responder #(
  parameter int          ADDR_WIDTH = 7,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_w,
  input  logic        mem_r,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dmtype,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic [31:0] err_addr
);

  // Handshake: mem_r/mem_w are single-cycle request strobes with no ready.
  // A load's rdata is valid combinationally in the strobe cycle; a store
  // commits at the rising edge that ends the strobe cycle. mem_w dominates mem_r.

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           ram [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  is_word, is_half, is_byte, sign_ext;
  logic                  mmio_hit, bad_align, misaligned;
  logic                  st_ok, ld_ok, ram_we, status_clr;
  logic [3:0]            be;
  logic [31:0]           wlanes;
  logic [31:0]           mmio_rd, word_rd, ext_rd;
  logic [15:0]           half_sel;
  logic [7:0]            byte_sel;
  logic [31:0]           cycle_cnt, load_cnt, store_cnt;

  assign idx      = addr[ADDR_WIDTH+1:2];
  assign mmio_hit = (addr[31:4] == MMIO_BASE[31:4]);

  always_comb begin
    is_word  = 1'b0;
    is_half  = 1'b0;
    is_byte  = 1'b0;
    sign_ext = 1'b0;
    case (dmtype)
      3'b001:  begin is_half = 1'b1; sign_ext = 1'b1; end
      3'b010:  is_half = 1'b1;
      3'b011:  begin is_byte = 1'b1; sign_ext = 1'b1; end
      3'b100:  is_byte = 1'b1;
      default: is_word = 1'b1;
    endcase
  end

  // The MMIO window only accepts aligned word accesses.
  always_comb begin
    bad_align = 1'b0;
    if (mmio_hit)     bad_align = !is_word || (addr[1:0] != 2'b00);
    else if (is_word) bad_align = (addr[1:0] != 2'b00);
    else if (is_half) bad_align = addr[0];
  end

  assign misaligned = (mem_r | mem_w) & bad_align;
  assign st_ok      = mem_w & ~bad_align;
  assign ld_ok      = mem_r & ~mem_w & ~bad_align;
  assign ram_we     = st_ok & ~mmio_hit & ~rst;
  assign status_clr = st_ok & mmio_hit & (addr[3:2] == 2'b11);

  always_comb begin
    be     = 4'b1111;
    wlanes = wdata;
    if (is_half) begin
      be     = addr[1] ? 4'b1100 : 4'b0011;
      wlanes = {2{wdata[15:0]}};
    end else if (is_byte) begin
      be     = 4'b0001 << addr[1:0];
      wlanes = {4{wdata[7:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  always_comb begin
    case (addr[3:2])
      2'b00:   mmio_rd = cycle_cnt;
      2'b01:   mmio_rd = load_cnt;
      2'b10:   mmio_rd = store_cnt;
      default: mmio_rd = {31'b0, misalign_err};
    endcase
  end

  assign word_rd  = mmio_hit ? mmio_rd : ram[idx];
  assign half_sel = addr[1] ? word_rd[31:16] : word_rd[15:0];

  always_comb begin
    case (addr[1:0])
      2'b00:   byte_sel = word_rd[7:0];
      2'b01:   byte_sel = word_rd[15:8];
      2'b10:   byte_sel = word_rd[23:16];
      default: byte_sel = word_rd[31:24];
    endcase
  end

  always_comb begin
    ext_rd = word_rd;
    if (is_half)      ext_rd = {{16{sign_ext & half_sel[15]}}, half_sel};
    else if (is_byte) ext_rd = {{24{sign_ext & byte_sel[7]}}, byte_sel};
  end

  assign rdata = ld_ok ? ext_rd : 32'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt    <= 32'b0;
      load_cnt     <= 32'b0;
      store_cnt    <= 32'b0;
      misalign_err <= 1'b0;
      err_addr     <= 32'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (ld_ok) load_cnt  <= load_cnt + 32'd1;
      if (st_ok) store_cnt <= store_cnt + 32'd1;
      // A new error takes priority over a clear; only the first address is kept.
      if (misaligned) begin
        misalign_err <= 1'b1;
        if (!misalign_err) err_addr <= addr;
      end else if (status_clr) begin
        misalign_err <= 1'b0;
        err_addr     <= 32'b0;
      end
    end
  end

endmodule
